// File: rtl/acc_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer and the ALU placed beside it.
package acc_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PC_W   = 8;

  // ALU unit select, carried in opcode[7:5].
  typedef enum logic [2:0] {
    UNIT_ADD   = 3'b000,
    UNIT_AND   = 3'b001,
    UNIT_SHIFT = 3'b010,
    UNIT_LOAD  = 3'b011,
    UNIT_OR    = 3'b100,
    UNIT_XOR   = 3'b101,
    UNIT_HALT  = 3'b110,
    UNIT_BNEZ  = 3'b111
  } unit_e;

  // Sequencer control states.
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    EXEC      = 2'd2,
    HALT      = 2'd3
  } state_e;

  // True in the two states that issue a byte fetch.
  function automatic logic is_fetch(state_e s);
    return (s == FETCH_OP) || (s == FETCH_ARG);
  endfunction

endpackage

// File: rtl/acc_sequencer.sv
// Two-byte instruction sequencer: fetches opcode and operand, drives an
// external ALU with the latched opcode fields and operands, and writes the
// ALU result back into the accumulator (or branches / halts).
//
// Fetch handshake: mem_req_out is a level request that stays high, with
// mem_addr_out stable, until a cycle where mem_ack_in=1; that cycle's
// mem_rdata_in is consumed on the same rising edge. mem_ack_in is ignored
// whenever no request is outstanding.
module acc_sequencer
  import acc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              mem_req_out,
  output logic [PC_W-1:0]   mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic [2:0]        unit_sel_out,
  output logic              op_sel_out,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] src_out,
  input  logic [DATA_W-1:0] alu_res_in,
  output logic              halted_out,
  output state_e            state_out
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] src_q, src_d;
  // Only opcode[7:4] carries meaning; the low nibble is never stored.
  logic [3:0]        opc_q, opc_d;
  unit_e             unit;

  assign unit = unit_e'(opc_q[3:1]);

  // State and datapath registers; reset wins over any ack or execute.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= FETCH_OP;
      pc_q    <= RESET_PC;
      acc_q   <= '0;
      src_q   <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      src_q   <= src_d;
      opc_q   <= opc_d;
    end
  end

  // Next-state and datapath update; everything holds unless a rule fires.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    src_d   = src_q;
    opc_d   = opc_q;
    case (state_q)
      FETCH_OP: begin
        if (mem_ack_in) begin
          opc_d   = mem_rdata_in[7:4];
          pc_d    = pc_q + 8'd1;
          state_d = FETCH_ARG;
        end
      end
      FETCH_ARG: begin
        if (mem_ack_in) begin
          src_d   = mem_rdata_in;
          pc_d    = pc_q + 8'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (unit)
          UNIT_HALT: begin
            state_d = HALT;
          end
          UNIT_BNEZ: begin
            if (acc_q != '0) pc_d = src_q;
            state_d = FETCH_OP;
          end
          default: begin
            acc_d   = alu_res_in;
            state_d = FETCH_OP;
          end
        endcase
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH_OP;
      end
    endcase
  end

  // Request is gated by reset so nothing is fetched while reset is held.
  assign mem_req_out  = is_fetch(state_q) && !rst_in;
  assign mem_addr_out = pc_q;
  assign unit_sel_out = opc_q[3:1];
  assign op_sel_out   = opc_q[0];
  assign acc_out      = acc_q;
  assign src_out      = src_q;
  assign halted_out   = (state_q == HALT);
  assign state_out    = state_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: a memory responder with variable ack latency, a
// bench-side ALU, an instruction-level reference model feeding expected
// queues, and a monitor that checks every fetch handshake and halt.
module tb_acc_sequencer;
  import acc_sequencer_pkg::*;

  localparam logic [7:0] RST_PC = 8'hFF;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       mem_ack_in = 1'b0;
  logic [7:0] mem_rdata_in = 8'h00;
  logic [7:0] alu_res_in;
  logic       mem_req_out;
  logic [7:0] mem_addr_out;
  logic [2:0] unit_sel_out;
  logic       op_sel_out;
  logic [7:0] acc_out;
  logic [7:0] src_out;
  logic       halted_out;
  state_e     state_out;

  always #5 clk = ~clk;

  acc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .mem_ack_in   (mem_ack_in),
    .mem_rdata_in (mem_rdata_in),
    .unit_sel_out (unit_sel_out),
    .op_sel_out   (op_sel_out),
    .acc_out      (acc_out),
    .src_out      (src_out),
    .alu_res_in   (alu_res_in),
    .halted_out   (halted_out),
    .state_out    (state_out)
  );

  logic [7:0] mem [256];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_acc_q[$];
  int         wait_fixed = 0;
  bit         force_ack = 1'b0;

  // Bench ALU: ADD (op=1 subtracts), AND, SHIFT (op=0 left, 1 right), LOAD, OR, XOR.
  function automatic logic [7:0] alu_f(logic [2:0] u, logic o, logic [7:0] a, logic [7:0] s);
    case (u)
      3'd0:    return o ? (a - s) : (a + s);
      3'd1:    return a & s;
      3'd2:    return o ? (a >> 1) : (a << 1);
      3'd3:    return s;
      3'd4:    return a | s;
      3'd5:    return a ^ s;
      default: return a;
    endcase
  endfunction

  always_comb alu_res_in = alu_f(unit_sel_out, op_sel_out, acc_out, src_out);

  task automatic check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int wcnt;
    int wtgt;
    bit prev_ack;
    wcnt = 0;
    wtgt = 0;
    prev_ack = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (prev_ack || rst_in) begin
        wcnt = 0;
        wtgt = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
      end
      if (force_ack) begin
        mem_ack_in   = 1'b1;
        mem_rdata_in = 8'h77;
      end else if (!rst_in && mem_req_out && wcnt >= wtgt) begin
        mem_ack_in   = 1'b1;
        mem_rdata_in = mem[mem_addr_out];
      end else begin
        mem_ack_in   = 1'b0;
        mem_rdata_in = 8'($urandom);
        if (mem_req_out) wcnt++;
      end
      prev_ack = mem_ack_in && mem_req_out;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit         first;
    bit         phase;
    bit         prev_wait;
    bit         prev_halt;
    logic [7:0] prev_addr;
    first = 1'b1;
    phase = 1'b0;
    prev_wait = 1'b0;
    prev_halt = 1'b0;
    prev_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        first = 1'b1;
        phase = 1'b0;
        prev_wait = 1'b0;
        prev_halt = 1'b0;
      end else begin
        if (prev_wait && mem_req_out) check("addr_stable", mem_addr_out, prev_addr);
        if (halted_out) check("no_req_halted", mem_req_out, 0);
        if (mem_req_out && mem_ack_in) begin
          if (exp_addr_q.size() == 0) check("fetch_expected", exp_addr_q.size(), 1);
          else check("fetch_addr", mem_addr_out, exp_addr_q.pop_front());
          if (!phase && !first) begin
            if (exp_acc_q.size() == 0) check("acc_expected", exp_acc_q.size(), 1);
            else check("acc_at_fetch", acc_out, exp_acc_q.pop_front());
          end
          if (!phase) first = 1'b0;
          phase = ~phase;
        end
        if (halted_out && !prev_halt) begin
          if (exp_acc_q.size() == 0) check("halt_expected", exp_acc_q.size(), 1);
          else check("acc_at_halt", acc_out, exp_acc_q.pop_front());
        end
        prev_wait = mem_req_out && !mem_ack_in;
        prev_addr = mem_addr_out;
        prev_halt = halted_out;
      end
    end
  end

  // ---------------- reference model ----------------
  // Executes up to n_max instructions from RST_PC; queues every fetch
  // address and the accumulator after each instruction.
  task automatic run_model(int n_max, output bit halts);
    logic [7:0] pc, acc, op, src;
    pc = RST_PC;
    acc = 8'h00;
    halts = 1'b0;
    for (int i = 0; i < n_max; i++) begin
      exp_addr_q.push_back(pc);
      op = mem[pc];
      pc = pc + 8'd1;
      exp_addr_q.push_back(pc);
      src = mem[pc];
      pc = pc + 8'd1;
      if (op[7:5] == 3'b110) begin
        halts = 1'b1;
      end else if (op[7:5] == 3'b111) begin
        if (acc != 8'h00) pc = src;
      end else begin
        acc = alu_f(op[7:5], op[4], acc, src);
      end
      exp_acc_q.push_back(acc);
      if (halts) break;
    end
    if (!halts) exp_addr_q.push_back(pc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_prog(logic [7:0] prog[$]);
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    for (int i = 0; i < prog.size(); i++) begin
      a = RST_PC + 8'(i);
      mem[a] = prog[i];
    end
  endtask

  task automatic run_test(string name, int n_max, int wfix, int exp_cyc, int exp_acc);
    bit halts;
    bit done;
    int cyc;
    wait_fixed = wfix;
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check({name, "_rst_req"}, mem_req_out, 0);
    check({name, "_rst_acc"}, acc_out, 0);
    check({name, "_rst_src"}, src_out, 0);
    check({name, "_rst_unit"}, unit_sel_out, 0);
    check({name, "_rst_op"}, op_sel_out, 0);
    check({name, "_rst_halt"}, halted_out, 0);
    exp_addr_q.delete();
    exp_acc_q.delete();
    run_model(n_max, halts);
    rst_in = 1'b0;
    #1;
    check({name, "_first_req"}, mem_req_out, 1);
    check({name, "_first_addr"}, mem_addr_out, RST_PC);
    cyc = 0;
    done = 1'b0;
    while (cyc < 3000 && !done) begin
      @(posedge clk);
      #2;
      cyc++;
      if (halted_out) done = 1'b1;
      else if (!halts && exp_addr_q.size() == 0) done = 1'b1;
    end
    check({name, "_done"}, done, 1);
    if (halts) begin
      if (exp_cyc > 0) check({name, "_cycles"}, cyc, exp_cyc);
      repeat (3) @(posedge clk);
      #2;
      check({name, "_halted"}, halted_out, 1);
      if (exp_acc >= 0) check({name, "_final_acc"}, acc_out, exp_acc);
      check({name, "_acc_q_left"}, exp_acc_q.size(), 0);
    end else begin
      rst_in = 1'b1;
    end
    check({name, "_addr_q_left"}, exp_addr_q.size(), 0);
  endtask

  // Reset pulsed while an operand ack is being presented.
  task automatic reset_mid_fetch();
    wait_fixed = 0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    exp_addr_q.delete();
    exp_acc_q.delete();
    exp_addr_q.push_back(RST_PC);
    rst_in = 1'b0;
    @(posedge clk);
    #2;
    check("mid_state_arg", state_out, FETCH_ARG);
    force_ack = 1'b1;
    rst_in = 1'b1;
    @(posedge clk);
    #2;
    check("mid_acc", acc_out, 0);
    check("mid_src", src_out, 0);
    check("mid_unit", unit_sel_out, 0);
    check("mid_req", mem_req_out, 0);
    check("mid_state", state_out, FETCH_OP);
    force_ack = 1'b0;
    check("mid_q_left", exp_addr_q.size(), 0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] prog[$];
    logic [7:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    prog = '{8'h60, 8'h05, 8'h00, 8'h03, 8'hC0, 8'h00};
    load_prog(prog);
    run_test("prog_basic", 20, 0, 9, 8'h08);
    run_test("prog_wait4", 20, 4, 33, 8'h08);

    tgt = RST_PC + 8'd2;
    prog = '{8'h60, 8'h03, 8'h10, 8'h01, 8'hE0, tgt, 8'hC0, 8'h00};
    load_prog(prog);
    run_test("countdown", 20, 0, 24, 8'h00);

    prog = '{8'h60, 8'h2A, 8'hC0, 8'h00};
    load_prog(prog);
    run_test("pc_wrap", 20, 0, 6, 8'h2A);

    prog = '{8'hE0, 8'h40, 8'h60, 8'h07, 8'hC0, 8'h00};
    load_prog(prog);
    run_test("bnez_zero", 20, 0, 9, 8'h07);

    prog = '{8'h60, 8'h55, 8'hC0, 8'h00};
    load_prog(prog);
    reset_mid_fetch();
    run_test("after_mid_rst", 20, 0, 6, 8'h55);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_test("rand", int'($urandom_range(2, 12)), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 8'h00, program counter value loaded on reset.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 mem_req_out  output  1  byte-fetch request, held until acknowledged.
REQ-005 mem_addr_out  output  8  fetch address (current PC), stable while mem_req_out=1.
REQ-006 mem_ack_in  input  1  fetch acknowledge; mem_rdata_in valid in the same cycle.
REQ-007 mem_rdata_in  input  8  fetched byte.
REQ-008 unit_sel_out  output  3  ALU unit select, from opcode[7:5].
REQ-009 op_sel_out  output  1  ALU op select, from opcode[4].
REQ-010 acc_out  output  8  accumulator register, drives ALU accumulator operand.
REQ-011 src_out  output  8  latched operand byte, drives ALU source operand.
REQ-012 alu_res_in  input  8  ALU combinational result.
REQ-013 halted_out  output  1  high while in HALT.

Function
REQ-014 Instruction SHALL be two bytes: opcode at PC, operand at PC+1; opcode[3:0] ignored.
REQ-015 States SHALL be FETCH_OP, FETCH_ARG, EXEC, HALT.
REQ-016 mem_req_out SHALL be 1 exactly in FETCH_OP and FETCH_ARG and 0 while rst_in=1.
REQ-017 FETCH_OP: on mem_ack_in=1, opcode register <= mem_rdata_in, PC <= PC+1, go FETCH_ARG; else remain, no state change.
REQ-018 FETCH_ARG: on mem_ack_in=1, src register <= mem_rdata_in, PC <= PC+1, go EXEC; else remain.
REQ-019 mem_ack_in outside fetch states SHALL be ignored.
REQ-020 unit_sel_out/op_sel_out SHALL reflect the latched opcode at all times (stable through EXEC).
REQ-021 EXEC, unit 000-101: acc <= alu_res_in; PC unchanged; go FETCH_OP; one cycle.
REQ-022 EXEC, unit 111 (bnez): acc unchanged; if acc_out != 0 then PC <= src, else PC unchanged; go FETCH_OP.
REQ-023 EXEC, unit 110 (reserved): acc unchanged; go HALT.
REQ-024 HALT SHALL be left only by reset; no fetches, acc and PC frozen.
REQ-025 PC SHALL be 8 bits and wrap 8'hFF -> 8'h00, including between opcode and operand bytes.
REQ-026 Minimum latency: 3 cycles per instruction with zero-wait acks; each wait cycle adds one.
REQ-027 Accumulator SHALL only change in EXEC; arithmetic wraps modulo 256 (ALU responsibility).

Reset
REQ-028 On rst_in=1 at clock edge: state=FETCH_OP, PC=RESET_PC, acc=0, opcode=0, src=0.
REQ-029 Reset outputs: mem_req_out=0, acc_out=0, src_out=0, unit_sel_out=0, op_sel_out=0, halted_out=0.
REQ-030 Reset SHALL take priority over any concurrent ack or EXEC, including mid-fetch; an in-flight ack during reset is discarded.
REQ-031 First fetch request SHALL appear the cycle after rst_in deasserts, at address RESET_PC.

Structure
REQ-032 Shared package SHALL hold unit_sel encodings (ADD=000, AND=001, SHIFT=010, LOAD=011, OR=100, XOR=101, HALT=110, BNEZ=111) and the state enum; ALU and sequencer both import it.
REQ-033 No sub-module; the ALU is instantiated alongside at top level, not inside this block.

Verification
REQ-034 Program {0x60,0x05, 0x00,0x03, 0xC0,0x00}, zero-wait acks -> acc 0x05 then 0x08, halted_out=1 after 9 cycles, no further mem_req_out.
REQ-035 Countdown {0x60,0x03, 0x10,0x01, 0xE0,0x02, 0xC0,0x00} -> acc 3,2,1,0; branch to 0x02 taken twice, falls through, halts with acc=0.
REQ-036 Ack delayed 4 cycles on each fetch -> mem_addr_out/mem_req_out held stable, instruction completes in 11 cycles, result identical.
REQ-037 RESET_PC=0xFF, opcode 0x60 at 0xFF, operand 0x2A at 0x00 -> acc=0x2A, next fetch at 0x01.
REQ-038 rst_in pulsed while in FETCH_ARG with mem_ack_in=1 -> operand discarded, acc=0, next request at RESET_PC.
REQ-039 bnez with acc=0x00 and operand 0x40 -> PC continues sequentially, acc unchanged.
